// File: rtl/qam_symbol_scheduler_pkg.sv
// Shared types and constants for the QAM transmit symbol scheduler.
package qam_pkg;

   // Symbol width: {sine sign, cosine sign}
   localparam int unsigned SYM_W   = 2;
   // Bit order: the first serial bit is the sine sign, the second the cosine sign
   localparam int unsigned SIN_BIT = 1;
   localparam int unsigned COS_BIT = 0;

   // Default build parameters and their derived values
   localparam int unsigned DEF_FREQ_PRESCALE       = 2;
   localparam int unsigned DEF_SAMPLES_PER_CARRIER = 32;
   localparam int unsigned DEF_CARRIERS_PER_SYMBOL = 4;
   localparam int unsigned DEF_FIFO_DEPTH          = 4;
   localparam int unsigned DEF_SAMPLES_PER_SYMBOL  =
      DEF_SAMPLES_PER_CARRIER * DEF_CARRIERS_PER_SYMBOL;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT_DATA,
      ST_RUN
   } state_t;

   // Width of a counter running 0..n-1 (at least one bit)
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/qam_symbol_scheduler_if.sv
// Control, serial-bit handshake and mixer-side bundle of the symbol scheduler.
interface qam_symbol_scheduler_if;
   import qam_pkg::*;

   logic             start;
   logic             stop;
   logic             bit_in;
   logic             bit_valid;
   logic             bit_ready;
   logic             sample_en;
   logic             phase_rst;
   logic [SYM_W-1:0] sym_out;
   logic             sym_valid;
   logic             busy;
   logic             underflow;
   logic [15:0]      sym_count;

   // Driver side (bit source / controller)
   modport master (
      output start, stop, bit_in, bit_valid,
      input  bit_ready, sample_en, phase_rst, sym_out, sym_valid, busy,
             underflow, sym_count
   );

   // Scheduler side
   modport slave (
      input  start, stop, bit_in, bit_valid,
      output bit_ready, sample_en, phase_rst, sym_out, sym_valid, busy,
             underflow, sym_count
   );
endinterface

// File: rtl/qam_symbol_scheduler_fifo.sv
// qam_sym_fifo: synchronous buffer of SYM_W-bit symbols.
// Push on full and pop on empty are silently dropped.
module qam_sym_fifo
   import qam_pkg::*;
#(
   parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   push_i,
   input  logic [SYM_W-1:0]       wdata_i,
   input  logic                   pop_i,
   output logic [SYM_W-1:0]       rdata_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [SYM_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   // Symbol storage; contents need no reset since pointers define validity
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

   // Pointer and occupancy tracking
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/qam_symbol_scheduler.sv
// QAM transmit scheduler: packs serial bits into symbols, buffers them and
// paces the sine/cosine LUT so each symbol lasts whole carrier periods.
module qam_symbol_scheduler
   import qam_pkg::*;
#(
   parameter int unsigned FREQ_PRESCALE       = DEF_FREQ_PRESCALE,
   parameter int unsigned SAMPLES_PER_CARRIER = DEF_SAMPLES_PER_CARRIER,
   parameter int unsigned CARRIERS_PER_SYMBOL = DEF_CARRIERS_PER_SYMBOL,
   parameter int unsigned FIFO_DEPTH          = DEF_FIFO_DEPTH
) (
   input  logic                 clk,
   input  logic                 rst,
   qam_symbol_scheduler_if.slave bus
);
   localparam int unsigned SAMPLES_PER_SYMBOL = SAMPLES_PER_CARRIER * CARRIERS_PER_SYMBOL;
   localparam int unsigned PW = cnt_w(FREQ_PRESCALE);
   localparam int unsigned SW = cnt_w(SAMPLES_PER_SYMBOL);
   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [PW-1:0] PRESC_LAST  = PW'(FREQ_PRESCALE - 1);
   localparam logic [SW-1:0] SAMPLE_LAST = SW'(SAMPLES_PER_SYMBOL - 1);

   state_t           state_q;
   logic [PW-1:0]    presc_q;
   logic [PW-1:0]    presc_d;
   logic [SW-1:0]    sample_cnt_q;
   logic             stop_pend_q;
   logic             half_q;
   logic             pack_msb_q;
   logic             sample_en_q;
   logic             phase_rst_q;
   logic [SYM_W-1:0] sym_q;
   logic             sym_valid_q;
   logic             busy_q;
   logic             underflow_q;
   logic [15:0]      sym_count_q;

   logic             bit_xfer;
   logic             push;
   logic [SYM_W-1:0] push_sym;
   logic             pop;
   logic             boundary;
   logic             stop_now;
   logic [SYM_W-1:0] fifo_rdata;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CW-1:0]    fifo_count;

   qam_sym_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i   (clk),
      .rst_i   (rst),
      .push_i  (push),
      .wdata_i (push_sym),
      .pop_i   (pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   // Handshake, packing and pop decisions, all decoded from registered state
   always_comb begin
      bus.bit_ready     = !half_q || !fifo_full;
      bit_xfer          = bus.bit_valid && bus.bit_ready;
      push              = bit_xfer && half_q;
      push_sym          = '0;
      push_sym[SIN_BIT] = pack_msb_q;
      push_sym[COS_BIT] = bus.bit_in;
      boundary          = (state_q == ST_RUN) && sample_en_q && (sample_cnt_q == SAMPLE_LAST);
      stop_now          = stop_pend_q || bus.stop;
      pop               = !fifo_empty &&
                          (((state_q == ST_WAIT_DATA) && !bus.stop) || (boundary && !stop_now));
      presc_d           = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
   end

   // sample_en is registered one cycle ahead: it is high exactly while the
   // prescaler sits at its last count, so it doubles as the internal strobe.
   // Sequencer FSM with packer and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         presc_q      <= '0;
         sample_cnt_q <= '0;
         stop_pend_q  <= 1'b0;
         half_q       <= 1'b0;
         pack_msb_q   <= 1'b0;
         sample_en_q  <= 1'b0;
         phase_rst_q  <= 1'b0;
         sym_q        <= '0;
         sym_valid_q  <= 1'b0;
         busy_q       <= 1'b0;
         underflow_q  <= 1'b0;
         sym_count_q  <= '0;
      end else begin
         phase_rst_q <= 1'b0;
         underflow_q <= 1'b0;
         sample_en_q <= 1'b0;

         if (bit_xfer) begin
            if (!half_q) begin
               pack_msb_q <= bus.bit_in;
               half_q     <= 1'b1;
            end else begin
               half_q     <= 1'b0;
            end
         end

         if (pop) begin
            sym_q       <= fifo_rdata;
            sym_count_q <= sym_count_q + 16'd1;
         end

         case (state_q)
            ST_IDLE: begin
               if (bus.start && !bus.stop) begin
                  state_q <= ST_WAIT_DATA;
                  busy_q  <= 1'b1;
               end
            end
            ST_WAIT_DATA: begin
               if (bus.stop) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end else if (!fifo_empty) begin
                  state_q      <= ST_RUN;
                  sym_valid_q  <= 1'b1;
                  phase_rst_q  <= 1'b1;
                  presc_q      <= '0;
                  sample_cnt_q <= '0;
                  sample_en_q  <= (PRESC_LAST == '0);
               end
            end
            ST_RUN: begin
               if (bus.stop) stop_pend_q <= 1'b1;
               presc_q <= presc_d;
               if (sample_en_q) sample_cnt_q <= boundary ? '0 : sample_cnt_q + SW'(1);
               if (boundary) begin
                  if (stop_now) begin
                     state_q     <= ST_IDLE;
                     busy_q      <= 1'b0;
                     sym_valid_q <= 1'b0;
                     stop_pend_q <= 1'b0;
                  end else if (!fifo_empty) begin
                     sample_en_q <= (presc_d == PRESC_LAST);
                  end else begin
                     state_q     <= ST_WAIT_DATA;
                     sym_valid_q <= 1'b0;
                     underflow_q <= 1'b1;
                  end
               end else begin
                  sample_en_q <= (presc_d == PRESC_LAST);
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Occupancy sanity: the buffer never reports more symbols than slots
   always_ff @(posedge clk) begin
      if (!rst) assert (fifo_count <= CW'(FIFO_DEPTH));
   end

   assign bus.sample_en = sample_en_q;
   assign bus.phase_rst = phase_rst_q;
   assign bus.sym_out   = sym_q;
   assign bus.sym_valid = sym_valid_q;
   assign bus.busy      = busy_q;
   assign bus.underflow = underflow_q;
   assign bus.sym_count = sym_count_q;

endmodule

// File: tb/tb_qam_symbol_scheduler.sv
// Self-checking bench for qam_symbol_scheduler: default build (A) and a
// fast build with FREQ_PRESCALE=1, CARRIERS_PER_SYMBOL=1 (B).
module tb_qam_symbol_scheduler;
   import qam_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   qam_symbol_scheduler_if a_if ();
   qam_symbol_scheduler_if b_if ();

   qam_symbol_scheduler #(
      .FREQ_PRESCALE(2), .SAMPLES_PER_CARRIER(32),
      .CARRIERS_PER_SYMBOL(4), .FIFO_DEPTH(4)
   ) dut_a (.clk(clk), .rst(rst), .bus(a_if));

   qam_symbol_scheduler #(
      .FREQ_PRESCALE(1), .SAMPLES_PER_CARRIER(32),
      .CARRIERS_PER_SYMBOL(1), .FIFO_DEPTH(4)
   ) dut_b (.clk(clk), .rst(rst), .bus(b_if));

   localparam int PER_A = 2 * 32 * 4;   // cycles per symbol, build A
   localparam int STR_A = 32 * 4;       // LUT strobes per symbol, build A
   localparam int PER_B = 1 * 32 * 1;   // cycles per symbol, build B

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Reference model: accepted bits pair up in arrival order into {first, second}
   logic       bitsA[$];
   logic [1:0] symsA[$];
   int         issuedA, seA, phA, ufA;
   logic       bitsB[$];
   logic [1:0] symsB[$];
   int         issuedB, ufB, gapB, lastB;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic stepA();
      logic acc, b;
      logic [15:0] prev;
      logic [31:0] exp;
      acc  = a_if.bit_valid && a_if.bit_ready;
      b    = a_if.bit_in;
      prev = a_if.sym_count;
      @(negedge clk);
      cyc++;
      if (acc) begin
         bitsA.push_back(b);
         if (bitsA.size() == 2) begin
            symsA.push_back({bitsA[0], bitsA[1]});
            bitsA.delete();
         end
      end
      if (a_if.sample_en) seA++;
      if (a_if.phase_rst) phA++;
      if (a_if.underflow) ufA++;
      if (a_if.sym_count != prev) begin
         issuedA++;
         chk("A sym_count step", 32'(a_if.sym_count), 32'(issuedA & 16'hFFFF));
         exp = (symsA.size() != 0) ? 32'(symsA.pop_front()) : 32'hDEAD;
         chk("A sym_out vs model", 32'(a_if.sym_out), exp);
      end
   endtask

   task automatic stepsA(input int n);
      for (int i = 0; i < n; i++) stepA();
   endtask

   task automatic stepB();
      logic acc, b;
      logic [15:0] prev;
      logic [31:0] exp;
      acc  = b_if.bit_valid && b_if.bit_ready;
      b    = b_if.bit_in;
      prev = b_if.sym_count;
      @(negedge clk);
      cyc++;
      if (acc) begin
         bitsB.push_back(b);
         if (bitsB.size() == 2) begin
            symsB.push_back({bitsB[0], bitsB[1]});
            bitsB.delete();
         end
      end
      if (b_if.underflow) ufB++;
      if (b_if.sym_valid && !b_if.sample_en) gapB++;
      if (b_if.sym_count != prev) begin
         issuedB++;
         exp = (symsB.size() != 0) ? 32'(symsB.pop_front()) : 32'hDEAD;
         chk("B sym_out vs model", 32'(b_if.sym_out), exp);
         if (issuedB > 1) chk("B symbol period", 32'(cyc - lastB), 32'(PER_B));
         lastB = cyc;
      end
   endtask

   task automatic chk_reset_a(input string tag);
      chk({tag, " bit_ready"}, 32'(a_if.bit_ready), 32'd1);
      chk({tag, " sample_en"}, 32'(a_if.sample_en), 32'd0);
      chk({tag, " phase_rst"}, 32'(a_if.phase_rst), 32'd0);
      chk({tag, " sym_out"},   32'(a_if.sym_out),   32'd0);
      chk({tag, " sym_valid"}, 32'(a_if.sym_valid), 32'd0);
      chk({tag, " busy"},      32'(a_if.busy),      32'd0);
      chk({tag, " underflow"}, 32'(a_if.underflow), 32'd0);
      chk({tag, " sym_count"}, 32'(a_if.sym_count), 32'd0);
   endtask

   initial begin
      int t0, t1, t2, t3, t4, acc_n, guard;
      logic r0, r1;

      rst = 1'b1;
      a_if.start = 1'b0; a_if.stop = 1'b0; a_if.bit_in = 1'b0; a_if.bit_valid = 1'b0;
      b_if.start = 1'b0; b_if.stop = 1'b0; b_if.bit_in = 1'b0; b_if.bit_valid = 1'b0;
      issuedA = 0; seA = 0; phA = 0; ufA = 0;
      issuedB = 0; ufB = 0; gapB = 0; lastB = 0;
      repeat (3) @(negedge clk);
      chk_reset_a("reset A");
      chk("reset B bit_ready", 32'(b_if.bit_ready), 32'd1);
      chk("reset B busy",      32'(b_if.busy),      32'd0);
      rst = 1'b0;

      // Preload 1,0,0,1 then start
      a_if.bit_valid = 1'b1;
      a_if.bit_in = 1'b1; stepA();
      a_if.bit_in = 1'b0; stepA();
      a_if.bit_in = 1'b0; stepA();
      a_if.bit_in = 1'b1; stepA();
      a_if.bit_valid = 1'b0;
      a_if.start = 1'b1; stepA(); a_if.start = 1'b0;
      chk("wait busy", 32'(a_if.busy), 32'd1);
      chk("wait sym_valid", 32'(a_if.sym_valid), 32'd0);
      stepA();
      t0 = cyc;
      chk("first sym_out", 32'(a_if.sym_out), 32'h2);
      chk("first phase_rst", 32'(a_if.phase_rst), 32'd1);
      chk("first sym_valid", 32'(a_if.sym_valid), 32'd1);
      chk("first sample_en early", 32'(a_if.sample_en), 32'd0);
      seA = 0; phA = 0;
      stepA();
      chk("phase_rst one cycle", 32'(a_if.phase_rst), 32'd0);
      chk("first strobe timing", 32'(a_if.sample_en), 32'd1);
      stepsA(PER_A - 2);
      chk("symbol held", 32'(a_if.sym_out), 32'h2);
      stepA();
      t1 = cyc;
      chk("second symbol spacing", 32'(t1 - t0), 32'(PER_A));
      chk("second sym_out", 32'(a_if.sym_out), 32'h1);
      chk("second sym_count", 32'(a_if.sym_count), 32'd2);
      chk("no phase_rst between symbols", 32'(phA), 32'd0);
      chk("strobes per symbol", 32'(seA), 32'(STR_A));

      // Single buffered symbol -> underflow, then restart
      ufA = 0;
      stepsA(PER_A - 1);
      chk("no early underflow", 32'(a_if.underflow), 32'd0);
      chk("valid before boundary", 32'(a_if.sym_valid), 32'd1);
      stepA();
      chk("underflow pulse", 32'(a_if.underflow), 32'd1);
      chk("muted on underflow", 32'(a_if.sym_valid), 32'd0);
      stepsA(10);
      chk("underflow count", 32'(ufA), 32'd1);
      chk("no strobe while waiting", 32'(a_if.sample_en), 32'd0);
      r0 = 1'($urandom); r1 = 1'($urandom);
      a_if.bit_valid = 1'b1;
      a_if.bit_in = r0; stepA();
      a_if.bit_in = r1; stepA();
      a_if.bit_valid = 1'b0;
      stepA();
      t2 = cyc;
      chk("restart phase_rst", 32'(a_if.phase_rst), 32'd1);
      chk("restart sym_out", 32'(a_if.sym_out), 32'({r0, r1}));
      seA = 0; ufA = 0;
      stepsA(PER_A - 1);
      chk("restart full symbol", 32'(a_if.underflow), 32'd0);
      stepA();
      chk("restart underflow at 256", 32'(a_if.underflow), 32'd1);
      chk("restart strobes from 0", 32'(seA), 32'(STR_A));
      a_if.stop = 1'b1; stepA(); a_if.stop = 1'b0;
      chk("stop from wait", 32'(a_if.busy), 32'd0);

      // Back-pressure in IDLE: 8 bits into FIFO, 9th held in packer
      acc_n = 0;
      a_if.bit_valid = 1'b1; a_if.bit_in = 1'($urandom);
      for (int i = 0; i < 15; i++) begin
         logic took;
         took = a_if.bit_ready;
         stepA();
         if (took) begin acc_n++; a_if.bit_in = 1'($urandom); end
      end
      chk("accepted while full", 32'(acc_n), 32'd9);
      chk("bit_ready dropped", 32'(a_if.bit_ready), 32'd0);
      a_if.start = 1'b1; stepA(); a_if.start = 1'b0;
      chk("ready before pop", 32'(a_if.bit_ready), 32'd0);
      stepA();
      t3 = cyc;
      chk("ready after pop", 32'(a_if.bit_ready), 32'd1);
      seA = 0;
      stepA();
      a_if.bit_valid = 1'b0;

      // stop at cycle 50 of a symbol with FIFO non-empty
      stepsA(49);
      a_if.stop = 1'b1; stepA(); a_if.stop = 1'b0;
      guard = 0;
      while (a_if.busy && guard < 400) begin stepA(); guard++; end
      chk("stop completes symbol", 32'(cyc - t3), 32'(PER_A));
      chk("stop strobes", 32'(seA), 32'(STR_A));
      chk("stop muted", 32'(a_if.sym_valid), 32'd0);
      chk("stop sym_count", 32'(a_if.sym_count), 32'd4);
      a_if.start = 1'b1; a_if.stop = 1'b1; stepA();
      a_if.start = 1'b0; a_if.stop = 1'b0;
      stepsA(3);
      chk("start+stop stays idle", 32'(a_if.busy), 32'd0);
      // FIFO survived the stop: next start plays the buffered symbol
      a_if.start = 1'b1; stepA(); a_if.start = 1'b0;
      stepA();
      t4 = cyc;
      chk("resume sym_count", 32'(a_if.sym_count), 32'd5);
      chk("resume phase_rst", 32'(a_if.phase_rst), 32'd1);

      // Reset mid-RUN at cycle 100
      stepsA(100 - (cyc - t4));
      rst = 1'b1;
      @(negedge clk); cyc++;
      chk_reset_a("mid-run reset");
      rst = 1'b0;
      bitsA.delete(); symsA.delete(); issuedA = 0;
      a_if.start = 1'b1; stepA(); a_if.start = 1'b0;
      seA = 0;
      stepsA(20);
      chk("empty wait busy", 32'(a_if.busy), 32'd1);
      chk("empty wait strobes", 32'(seA), 32'd0);
      chk("empty wait sym_valid", 32'(a_if.sym_valid), 32'd0);
      a_if.stop = 1'b1; stepA(); a_if.stop = 1'b0;
      chk("A idle at end", 32'(a_if.busy), 32'd0);

      // Build B: 100 streamed symbols of 32 cycles each
      b_if.bit_valid = 1'b1; b_if.bit_in = 1'($urandom);
      b_if.start = 1'b1; stepB(); b_if.start = 1'b0;
      guard = 0;
      while (b_if.sym_count != 16'd100 && guard < 100 * PER_B + 200) begin
         b_if.bit_in = 1'($urandom);
         stepB();
         guard++;
      end
      b_if.stop = 1'b1; stepB(); b_if.stop = 1'b0;
      b_if.bit_valid = 1'b0;
      guard = 0;
      while (b_if.busy && guard < 100) begin stepB(); guard++; end
      chk("B stopped", 32'(b_if.busy), 32'd0);
      chk("B sym_count", 32'(b_if.sym_count), 32'd100);
      chk("B no underflow", 32'(ufB), 32'd0);
      chk("B strobe every cycle", 32'(gapB), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
